// File: rtl/utils_pkg.sv
// ----------------------------------------------------------------------------
// utils_pkg
// Shared helpers for the FIFO family (single- and dual-clock).
//
// Contents:
//   next_ptr(ptr, depth) : advance a 0..depth-1 index, wrapping depth-1 -> 0
//                          by compare, so any depth works (not only 2^n).
// ----------------------------------------------------------------------------
package utils_pkg;

    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage : utils_pkg

// File: rtl/fifo_mem.sv
// ----------------------------------------------------------------------------
// fifo_mem
// Width x Depth flop array with one synchronous write port and one
// asynchronous read port. Holds no control state, so it is shared by the
// single-clock and dual-clock FIFOs.
//
// Ports:
//   clk_i    in  1        write clock
//   we_i     in  1        write enable
//   waddr_i  in  AddrW    write address, 0..Depth-1
//   wdata_i  in  Width    write data
//   raddr_i  in  AddrW    read address, 0..Depth-1
//   rdata_o  out Width    mem[raddr_i], combinational
// ----------------------------------------------------------------------------
module fifo_mem #(
    parameter int Width = 8,
    parameter int Depth = 8,
    parameter int AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // NOTE: the storage array has no reset; occupancy is tracked by the
    // controller, so stale words are never observable and reset fan-out to
    // every bit is avoided.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO of any Depth >= 2 with all entries usable. Read side is
// either registered (data_o valid the cycle after an accepted read) or
// first-word-fall-through. Provides fill level, almost-full/almost-empty
// thresholds, flush and sticky overflow/underflow flags.
//
// Ports:
//   clk_i           in   1      clock
//   rst_i           in   1      synchronous reset, active-high
//   flush_i         in   1      synchronous clear of contents and error flags
//   read_req_i      in   1      pop request
//   read_valid_o    out  1      not empty; read accepted on req && valid
//   data_o          out  Width  read data
//   write_req_i     in   1      push request
//   write_valid_o   out  1      not full; write accepted on req && valid
//   data_i          in   Width  write data
//   level_o         out  LvlW   occupancy 0..Depth
//   almost_full_o   out  1      level_o >= AlmostFull
//   almost_empty_o  out  1      level_o <= AlmostEmpty
//   overflow_o      out  1      sticky: write requested while full
//   underflow_o     out  1      sticky: read requested while empty
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int Width       = 8,
    parameter int Depth       = 8,
    parameter int FallThrough = 0,
    parameter int AlmostFull  = 6,
    parameter int AlmostEmpty = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       read_req_i,
    output logic                       read_valid_o,
    output logic [Width-1:0]           data_o,
    input  logic                       write_req_i,
    output logic                       write_valid_o,
    input  logic [Width-1:0]           data_i,
    output logic [$clog2(Depth+1)-1:0] level_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    import utils_pkg::*;

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int LvlW = $clog2(Depth + 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (Depth < 2) begin : g_chk_depth
        $error("sync_fifo: Depth must be >= 2");
    end
    if (!(AlmostEmpty >= 0 && AlmostEmpty < AlmostFull && AlmostFull <= Depth))
    begin : g_chk_thresh
        $error("sync_fifo: need 0 <= AlmostEmpty < AlmostFull <= Depth");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q,  level_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;

    logic             wr_en;
    logic             rd_en;
    logic [Width-1:0] mem_rdata;

    // Full/empty come straight from the level register, so a same-cycle read
    // never frees a slot for a write and a same-cycle write never feeds a read.
    assign read_valid_o  = (level_q != '0);
    assign write_valid_o = (level_q != LvlW'(Depth));

    assign wr_en = write_req_i && write_valid_o;
    assign rd_en = read_req_i  && read_valid_o;

    // NOTE: every signal written here is given its default first, so each
    // path assigns it and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = PtrW'(next_ptr(int'(wr_ptr_q), Depth));
            end
            if (rd_en) begin
                rd_ptr_d = PtrW'(next_ptr(int'(rd_ptr_q), Depth));
            end
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (write_req_i && !write_valid_o) ovf_d = 1'b1;
            if (read_req_i  && !read_valid_o)  unf_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    fifo_mem #(
        .Width (Width),
        .Depth (Depth),
        .AddrW (PtrW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en && !flush_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // ------------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------------
    if (FallThrough != 0) begin : g_fwft
        // Head word is presented as soon as it is stored; valid with read_valid_o.
        assign data_o = mem_rdata;
    end else begin : g_reg
        logic [Width-1:0] data_q;

        // Loads only on an accepted read; flush and refused reads hold it.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                data_q <= '0;
            end else if (rd_en && !flush_i) begin
                data_q <= mem_rdata;
            end
        end

        assign data_o = data_q;
    end

    // ------------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------------
    assign level_o        = level_q;
    assign almost_full_o  = (level_q >= LvlW'(AlmostFull));
    assign almost_empty_o = (level_q <= LvlW'(AlmostEmpty));
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule : sync_fifo
